// File: rtl/execute_stage_pkg.sv
// Shared types for the execute stage: RF address/data words, ALU opcodes,
// operand-select encodings and the two pipe-register layouts.
package execute_stage_pkg;

    localparam int PKG_DATA_W = 16;
    localparam int PKG_ADRS_W = 3;

    typedef logic [PKG_ADRS_W-1:0] t_RFadrs;
    typedef logic [PKG_DATA_W-1:0] t_data;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SHL  = 3'd5,
        ALU_SHR  = 3'd6,
        ALU_PASS = 3'd7
    } t_ALUop;

    localparam logic SRC1_DAT  = 1'b0;
    localparam logic SRC1_ZERO = 1'b1;
    localparam logic SRC2_DAT  = 1'b0;
    localparam logic SRC2_IMM  = 1'b1;

    // An all-zero value of either struct is a bubble.
    typedef struct packed {
        logic    wr_en;
        logic    dataoutv;
        t_ALUop  alu_op;
        logic    src1_sel;
        logic    src2_sel;
        t_RFadrs src1;
        t_RFadrs src2;
        t_RFadrs dst;
        t_data   dat1;
        t_data   dat2;
        t_data   imm;
    } t_IDtoEX;

    typedef struct packed {
        logic    wr_en;
        logic    dataoutv;
        t_RFadrs dst;
        t_data   data;
    } t_EXtoWB;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational ALU; all arithmetic wraps modulo 2^DATA_W.
module alu
    import execute_stage_pkg::*;
#(
    parameter int DATA_W = PKG_DATA_W
) (
    input  t_ALUop            op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] sh;
    assign sh = b[SH_W-1:0];

    always_comb begin
        y = b;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SHL:  y = a << sh;
            ALU_SHR:  y = a >> sh;
            ALU_PASS: y = b;
            default:  y = b;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ID/EX capture with RF-bypass forwarding, x1 ALU with
// EX/WB forwarding, and the EX/WB register driving write-back and dataout.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int DATA_W = PKG_DATA_W,
    parameter int ADRS_W = PKG_ADRS_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              internal_reset,
    input  logic              stalled,
    input  logic              ALUsrc1x0,
    input  logic              ALUsrc2x0,
    input  logic [2:0]        ALUopx0,
    input  logic              wr_enx0,
    input  logic              dataoutvx0,
    input  logic [DATA_W-1:0] dat1x0,
    input  logic [DATA_W-1:0] dat2x0,
    input  logic [ADRS_W-1:0] src1x0,
    input  logic [ADRS_W-1:0] src2x0,
    input  logic [DATA_W-1:0] immx0,
    input  logic [ADRS_W-1:0] dstx0,
    output logic [ADRS_W-1:0] dstx2,
    output logic [DATA_W-1:0] dataoutx2,
    output logic              wr_enx2,
    output logic [DATA_W-1:0] dataout,
    output logic              dataoutv
);

    t_IDtoEX idex, idex_next;
    t_EXtoWB exwb;

    logic [DATA_W-1:0] opd1, opd2, opa, opb, alu_y;

    // The RF write at x2 lands in the same cycle as the x0 read, so the
    // read data is stale for a matching address and must be bypassed here.
    always_comb begin
        idex_next = '0;
        if (!stalled && !internal_reset) begin
            idex_next.wr_en    = wr_enx0;
            idex_next.dataoutv = dataoutvx0;
            idex_next.alu_op   = t_ALUop'(ALUopx0);
            idex_next.src1_sel = ALUsrc1x0;
            idex_next.src2_sel = ALUsrc2x0;
            idex_next.src1     = src1x0;
            idex_next.src2     = src2x0;
            idex_next.dst      = dstx0;
            idex_next.imm      = immx0;
            idex_next.dat1     = (exwb.wr_en && exwb.dst == src1x0) ? exwb.data : dat1x0;
            idex_next.dat2     = (exwb.wr_en && exwb.dst == src2x0) ? exwb.data : dat2x0;
        end
    end

    // The EX/WB entry is the younger producer, so it overrides the captured value.
    assign opd1 = (exwb.wr_en && exwb.dst == idex.src1) ? exwb.data : idex.dat1;
    assign opd2 = (exwb.wr_en && exwb.dst == idex.src2) ? exwb.data : idex.dat2;
    assign opa  = (idex.src1_sel == SRC1_ZERO) ? '0 : opd1;
    assign opb  = (idex.src2_sel == SRC2_IMM) ? idex.imm : opd2;

    alu #(.DATA_W(DATA_W)) u_alu (
        .op (idex.alu_op),
        .a  (opa),
        .b  (opb),
        .y  (alu_y)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idex <= '0;
            exwb <= '0;
        end else begin
            idex <= idex_next;
            if (internal_reset)
                exwb <= '0;
            else begin
                exwb.wr_en    <= idex.wr_en;
                exwb.dataoutv <= idex.dataoutv;
                exwb.dst      <= idex.dst;
                exwb.data     <= alu_y;
            end
        end
    end

    assign dstx2     = exwb.dst;
    assign dataoutx2 = exwb.data;
    assign wr_enx2   = exwb.wr_en;
    assign dataout   = exwb.data;
    assign dataoutv  = exwb.dataoutv;

endmodule

// File: tb/tb_execute_stage.sv
// Directed and random checks of execute_stage against an in-order
// architectural model (register file plus two in-flight result slots).
module tb_execute_stage;

    logic        clock = 1'b0;
    logic        reset, internal_reset, stalled;
    logic        ALUsrc1x0, ALUsrc2x0, wr_enx0, dataoutvx0;
    logic [2:0]  ALUopx0;
    logic [15:0] dat1x0, dat2x0, immx0;
    logic [2:0]  src1x0, src2x0, dstx0;
    logic [2:0]  dstx2;
    logic [15:0] dataoutx2, dataout;
    logic        wr_enx2, dataoutv;

    execute_stage #(.DATA_W(16), .ADRS_W(3)) dut (
        .clock(clock), .reset(reset), .internal_reset(internal_reset), .stalled(stalled),
        .ALUsrc1x0(ALUsrc1x0), .ALUsrc2x0(ALUsrc2x0), .ALUopx0(ALUopx0),
        .wr_enx0(wr_enx0), .dataoutvx0(dataoutvx0),
        .dat1x0(dat1x0), .dat2x0(dat2x0), .src1x0(src1x0), .src2x0(src2x0),
        .immx0(immx0), .dstx0(dstx0),
        .dstx2(dstx2), .dataoutx2(dataoutx2), .wr_enx2(wr_enx2),
        .dataout(dataout), .dataoutv(dataoutv)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit stl, fl, s1, s2, we, dov, hk;
        bit [2:0] op, a1, a2, d;
        bit [15:0] imm, k;
    } ins_t;

    typedef struct {
        bit live, we, dov, hk;
        bit [2:0] dst;
        bit [15:0] res, k;
    } slot_t;

    int nvec = 0;
    int nerr = 0;
    bit [15:0] rf [8];
    slot_t s1, s2;
    slot_t bub;
    logic [15:0] sweep_k [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit [15:0] ref_alu(input bit [2:0] op, input bit [15:0] a, input bit [15:0] b);
        int unsigned sh;
        sh = b % 16;
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return a << sh;
            6: return a >> sh;
            default: return b;
        endcase
    endfunction

    // Architectural value of a register as seen by the instruction issuing now.
    function automatic bit [15:0] arch(input bit [2:0] r);
        if (s1.live && s1.we && s1.dst == r) return s1.res;
        if (s2.live && s2.we && s2.dst == r) return s2.res;
        return rf[r];
    endfunction

    function automatic ins_t mk(input bit [2:0] op, input bit we, input bit dov,
                                input bit [2:0] a1, input bit [2:0] a2, input bit [2:0] d,
                                input bit sel1, input bit sel2, input bit [15:0] imm);
        ins_t i;
        i = '{default: '0};
        i.op = op; i.we = we; i.dov = dov; i.a1 = a1; i.a2 = a2; i.d = d;
        i.s1 = sel1; i.s2 = sel2; i.imm = imm;
        return i;
    endfunction

    function automatic ins_t bubble_ins();
        ins_t i;
        i = mk(3'd7, 1'b1, 1'b1, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1, 16'hBEEF);
        i.stl = 1'b1;
        return i;
    endfunction

    // One clock: drive x0 at posedge+1, check x2 at negedge, advance model.
    task automatic step(input ins_t i);
        slot_t nw;
        bit [15:0] a, b;
        stalled = i.stl; internal_reset = i.fl;
        ALUsrc1x0 = i.s1; ALUsrc2x0 = i.s2; ALUopx0 = i.op;
        wr_enx0 = i.we; dataoutvx0 = i.dov;
        src1x0 = i.a1; src2x0 = i.a2; dstx0 = i.d; immx0 = i.imm;
        dat1x0 = rf[i.a1]; dat2x0 = rf[i.a2];
        a = i.s1 ? 16'h0 : arch(i.a1);
        b = i.s2 ? i.imm : arch(i.a2);
        nw = '{live: 1'b1, we: i.we, dov: i.dov, hk: i.hk, dst: i.d,
               res: ref_alu(i.op, a, b), k: i.k};
        @(negedge clock);
        chk("wr_enx2", wr_enx2, s2.we);
        chk("dataoutv", dataoutv, s2.dov);
        if (s2.we || s2.dov) chk("dstx2", dstx2, s2.dst);
        if (s2.live) begin
            chk("dataoutx2", dataoutx2, s2.res);
            chk("dataout", dataout, s2.res);
        end
        if (s2.hk) chk("const", dataoutx2, s2.k);
        @(posedge clock);
        #1;
        if (s2.live && s2.we) rf[s2.dst] = s2.res;
        if (i.fl) begin
            s2 = bub; s1 = bub;
        end else begin
            s2 = s1;
            s1 = i.stl ? bub : nw;
        end
    endtask

    initial begin
        ins_t t;
        bub = '{default: '0};
        s1 = bub; s2 = bub;
        foreach (rf[r]) rf[r] = '0;
        sweep_k = '{16'h0003, 16'hFFDD, 16'h0010, 16'hFFF3, 16'hFFE3, 16'hFF80, 16'h1FFE, 16'h0013};
        reset = 1'b1; internal_reset = 1'b0; stalled = 1'b1;
        ALUsrc1x0 = 0; ALUsrc2x0 = 0; ALUopx0 = 0; wr_enx0 = 0; dataoutvx0 = 0;
        dat1x0 = 0; dat2x0 = 0; src1x0 = 0; src2x0 = 0; immx0 = 0; dstx0 = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_dstx2", dstx2, 3'd0);
        chk("rst_dataoutx2", dataoutx2, 16'd0);
        chk("rst_wr_enx2", wr_enx2, 1'b0);
        chk("rst_dataout", dataout, 16'd0);
        chk("rst_dataoutv", dataoutv, 1'b0);
        reset = 1'b0;

        // Back-to-back: r1 = PASS 5, then r2 = r1 + r1 with stale RF
        t = mk(3'd7, 1, 1, 3'd0, 3'd0, 3'd1, 0, 1, 16'd5); step(t);
        t = mk(3'd0, 1, 1, 3'd1, 3'd1, 3'd2, 0, 0, 16'd0); t.hk = 1; t.k = 16'd10; step(t);
        // Gap of one: r3 = PASS 7, bubble, r4 = r3 + 1
        t = mk(3'd7, 1, 0, 3'd0, 3'd0, 3'd3, 0, 1, 16'd7); step(t);
        step(bubble_ins());
        t = mk(3'd0, 1, 1, 3'd3, 3'd0, 3'd4, 0, 1, 16'd1); t.hk = 1; t.k = 16'd8; step(t);

        // ALU sweep with A = 0xFFF0 in r6 and imm 0x0013
        t = mk(3'd7, 1, 0, 3'd0, 3'd0, 3'd6, 0, 1, 16'hFFF0); step(t);
        for (int op = 0; op < 8; op++) begin
            t = mk(3'(op), 1, 1, 3'd6, 3'd5, 3'd7, 0, 1, 16'h0013);
            t.hk = 1; t.k = sweep_k[op];
            step(t);
        end

        // Stall for two cycles between two writers
        t = mk(3'd7, 1, 1, 3'd0, 3'd0, 3'd1, 0, 1, 16'h1111); step(t);
        step(bubble_ins());
        step(bubble_ins());
        t = mk(3'd0, 1, 1, 3'd1, 3'd1, 3'd2, 0, 0, 16'h0); t.hk = 1; t.k = 16'h2222; step(t);

        // Flush with two writers in flight; the next instruction completes
        t = mk(3'd7, 1, 1, 3'd0, 3'd0, 3'd5, 0, 1, 16'h0AAA); step(t);
        t = mk(3'd7, 1, 1, 3'd0, 3'd0, 3'd5, 0, 1, 16'h0BBB); step(t);
        t = mk(3'd7, 1, 1, 3'd0, 3'd0, 3'd5, 0, 1, 16'h0CCC); t.fl = 1; step(t);
        t = mk(3'd0, 1, 1, 3'd5, 3'd0, 3'd6, 0, 1, 16'h0001); t.hk = 1; t.k = rf[5] + 16'd1; step(t);
        step(bubble_ins());
        step(bubble_ins());

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            t = mk(3'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
                   3'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 16'($urandom));
            t.stl = ($urandom_range(0, 7) == 0);
            t.fl  = ($urandom_range(0, 15) == 0);
            step(t);
        end

        // Asynchronous reset with x1/x2 full
        t = mk(3'd7, 1, 1, 3'd0, 3'd0, 3'd1, 0, 1, 16'h1234); step(t);
        t = mk(3'd7, 1, 1, 3'd0, 3'd0, 3'd2, 0, 1, 16'h5678); step(t);
        #2 reset = 1'b1;
        #1;
        chk("async_dstx2", dstx2, 3'd0);
        chk("async_dataoutx2", dataoutx2, 16'd0);
        chk("async_wr_enx2", wr_enx2, 1'b0);
        chk("async_dataout", dataout, 16'd0);
        chk("async_dataoutv", dataoutv, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        s1 = bub; s2 = bub;
        t = mk(3'd7, 1, 1, 3'd0, 3'd0, 3'd3, 0, 1, 16'h00A5); t.hk = 1; t.k = 16'h00A5; step(t);
        step(bubble_ins());
        step(bubble_ins());

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the pipelined microcontroller, directly downstream of the decode stage. It captures the decoder's x0 control and operand fields into the ID/EX register, forwards in-flight results, evaluates the ALU in x1, and registers the result into the EX/WB register. It drives the x2 write-back bus back to the register file, plus the machine's `dataout`/`dataoutv` outputs.

## Interface
Parameters:
- `DATA_W`, 16, datapath / register-file word width
- `ADRS_W`, 3, register-file address width (`t_RFadrs`)

Ports. One clock; reset is asynchronous and active-high.
- `clock` in 1: pipeline clock, rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `internal_reset` in 1: synchronous flush from controller
- `stalled` in 1: controller stall; x0 fields must not enter the pipe this cycle
- `ALUsrc1x0` in 1: operand A select, 0 = `dat1x0`, 1 = constant 0
- `ALUsrc2x0` in 1: operand B select, 0 = `dat2x0`, 1 = `immx0`
- `ALUopx0` in 3: ALU operation (`t_ALUop`)
- `wr_enx0` in 1: instruction writes `dstx0`
- `dataoutvx0` in 1: instruction publishes its result on `dataout`
- `dat1x0`, `dat2x0` in DATA_W: RF read data
- `src1x0`, `src2x0` in ADRS_W: RF read addresses, used for forwarding
- `immx0` in DATA_W: immediate
- `dstx0` in ADRS_W: destination register
- `dstx2` out ADRS_W: write-back address
- `dataoutx2` out DATA_W: write-back data
- `wr_enx2` out 1: write-back enable
- `dataout` out DATA_W: machine output data, equals `dataoutx2`
- `dataoutv` out 1: machine output valid

## Operation
- **ID/EX register (x1).** It loads every clock.
  - When `stalled` is 1 or `internal_reset` is 1, it loads a bubble: `wr_en = 0`, `dataoutv = 0`, data fields 0.
  - Otherwise it loads the x0 fields.
- **Capture-time forwarding.** When loading a non-bubble, if `wr_enx2` is 1 and `dstx2 == src1x0`, store `dataoutx2` instead of `dat1x0`. Apply the same rule to `src2x0`/`dat2x0`. This covers the RF write landing in the same cycle as the read.
- **x1 forwarding.** If the EX/WB entry has `wr_en` set and its `dst` matches the x1 entry's `src1` or `src2`, that operand is replaced by the EX/WB data. This takes priority over the captured value.
- **Forwarding scope.** Forwarding applies only to the `dat` paths, never to `imm`. There is no hardwired zero register.
- **ALU ops (`t_ALUop`).** All arithmetic is modulo 2^DATA_W, with no carry-out.
  - ADD = 0: A+B
  - SUB = 1: A−B
  - AND = 2
  - OR = 3
  - XOR = 4
  - SHL = 5: A << B[log2(DATA_W)-1:0]
  - SHR = 6: logical right shift by the same amount
  - PASS = 7: B
- **EX/WB register (x2).** Loads the ALU result, `dst`, `wr_en` and `dataoutv` every clock. `internal_reset` loads a bubble.
- **Outputs.** `dataout`/`dataoutv` and the x2 write-back bus are driven directly from the EX/WB register.
  - `dataoutv` is 1 only when the x2 instruction has `dataoutv` set.
  - `dataout` holds the x2 value regardless of `dataoutv`.

## Timing
- **Latency.** An instruction presented at x0 in cycle n computes in n+1. It appears on the x2 outputs in n+2, and the RF is written at the end of n+2.
- **Throughput.** One instruction per cycle. No internal stall source.
- **Reset.** While `reset` is high, and immediately on its assertion (asynchronous), all outputs are 0: `dstx2`, `dataoutx2`, `wr_enx2`, `dataout`, `dataoutv`. Both pipe registers are also 0, i.e. bubbles.
- **`internal_reset`.** Asserted in cycle n: both registers hold bubbles from n+1, so `wr_enx2 = 0` and `dataoutv = 0` in n+1. In-flight instructions are discarded without writing.
- **Stall with flush.** `stalled` together with `internal_reset` gives a flush; the effects are identical.
- **Dual match.** When both sources match the same `dst`, both operands are forwarded.

## Structure
- Shared package: `t_RFadrs`, `t_data`, `t_ALUop` enum, the `ALUsrc` encodings, and the pipe-register struct types `t_IDtoEX` and `t_EXtoWB`.
- Sub-module: `alu` (combinational, parameterised by `DATA_W`). Forwarding muxes and both pipe registers stay in `execute_stage`.

## Test plan
- **Reset.** Assert `reset` mid-stream with x1/x2 full → all outputs 0 immediately. After deassert, the first result appears 2 cycles after the first presented instruction.
- **ALU sweep.** Operands A=0xFFF0, imm=0x0013, with `ALUsrc2x0=1`. Each op → ADD 0x0003, SUB 0xFFDD, AND 0x0010, OR 0xFFF3, XOR 0xFFE3, SHL 0xFF80, SHR 0x1FFE, PASS 0x0013.
- **Back-to-back dependency.** `r1 = 5+0` (PASS imm 5), next cycle `r2 = r1+r1`, where the RF still returns stale r1 = 0 → `dataoutx2 = 10`.
- **Gap-of-one dependency.** `r3 = PASS 7`, a bubble, then `r4 = r3 ADD imm 1` read in the write cycle with stale RF → capture forwarding gives 8.
- **Stall.** `stalled=1` for 2 cycles with valid-looking x0 fields → `wr_enx2 = 0` and `dataoutv = 0` in the two corresponding x2 cycles. Surrounding instructions are unaffected.
- **Flush.** Two writing instructions in flight, `internal_reset` pulsed for 1 cycle → neither produces `wr_enx2 = 1`. The next instruction completes normally.
